tank_move_sched: RTL and testbench

- Per-frame motion scheduler for both tanks.
- On each frame tick it latches each player's requested direction, then steps each tank one pixel at a time, up to STEPS pixels.
- One wall-collision checker (single-tank instance) is time-shared between the two tanks. Every step is gated by the checker verdict and the screen bounds.
- The block owns the tank position and facing registers consumed by the sprite/VGA path and the bullet logic.

---
 rtl/tank_move_sched.sv | 172 +++++++++++++++++
 tb/tb_tank_move_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tank_move_sched.sv
// Per-frame tank motion scheduler: one frame_tick latches both requests, then each tank steps up to STEPS pixels through one shared wall checker.
// Latency 2*STEPS+2 cycles worst case per frame; no backpressure, and ticks arriving while busy are dropped.
module tank_move_sched #(
  parameter int          STEPS   = 2,
  parameter logic [9:0]  INIT_X1 = 10'd64,
  parameter logic [9:0]  INIT_Y1 = 10'd64,
  parameter logic [9:0]  INIT_X2 = 10'd544,
  parameter logic [9:0]  INIT_Y2 = 10'd384,
  parameter logic [9:0]  X_MAX   = 10'd608,
  parameter logic [9:0]  Y_MAX   = 10'd448
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic [2:0] dir_req1,
  input  logic [2:0] dir_req2,
  output logic [9:0] chk_x,
  output logic [9:0] chk_y,
  output logic [2:0] chk_dir,
  input  logic       chk_ok,
  output logic [9:0] X_Tank1,
  output logic [9:0] Y_Tank1,
  output logic [9:0] X_Tank2,
  output logic [9:0] Y_Tank2,
  output logic [2:0] face1,
  output logic [2:0] face2,
  output logic       busy,
  output logic       done,
  output logic       blocked1,
  output logic       blocked2
);

  typedef enum logic [1:0] {IDLE, PH_A, PH_B, DONE} state_t;

  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_DOWN  = 3'd4;
  localparam logic [3:0] STEPS_L   = 4'(STEPS);

  state_t     state;
  logic       first;
  logic [3:0] cnt;
  logic [2:0] dir1_q;
  logic [2:0] dir2_q;

  logic       in_phase;
  logic       served2;
  logic [9:0] cur_x;
  logic [9:0] cur_y;
  logic [2:0] cur_dir;
  logic       bound_ok;
  logic       step_ok;
  logic       phase_end;
  logic [9:0] nxt_x;
  logic [9:0] nxt_y;

  function automatic logic [2:0] sanitize(input logic [2:0] d);
    return (d >= 3'd1 && d <= 3'd4) ? d : 3'd0;
  endfunction

  // PH_A serves the tank selected by `first`, PH_B the other one.
  always_comb begin
    in_phase = (state == PH_A) || (state == PH_B);
    served2  = (state == PH_B) ? ~first : first;
    cur_x    = served2 ? X_Tank2 : X_Tank1;
    cur_y    = served2 ? Y_Tank2 : Y_Tank1;
    cur_dir  = served2 ? dir2_q : dir1_q;
    chk_x    = cur_x;
    chk_y    = cur_y;
    chk_dir  = in_phase ? cur_dir : 3'd0;
  end

  always_comb begin
    bound_ok = 1'b0;
    nxt_x    = cur_x;
    nxt_y    = cur_y;
    case (cur_dir)
      DIR_UP: begin
        bound_ok = (cur_y != 10'd0);
        nxt_y    = cur_y - 10'd1;
      end
      DIR_RIGHT: begin
        bound_ok = (cur_x < X_MAX);
        nxt_x    = cur_x + 10'd1;
      end
      DIR_LEFT: begin
        bound_ok = (cur_x != 10'd0);
        nxt_x    = cur_x - 10'd1;
      end
      DIR_DOWN: begin
        bound_ok = (cur_y < Y_MAX);
        nxt_y    = cur_y + 10'd1;
      end
      default: bound_ok = 1'b0;
    endcase
    step_ok   = in_phase && chk_ok && bound_ok;
    phase_end = in_phase && (!step_ok || cnt == 4'd1);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      first    <= 1'b0;
      cnt      <= 4'd0;
      dir1_q   <= 3'd0;
      dir2_q   <= 3'd0;
      X_Tank1  <= INIT_X1;
      Y_Tank1  <= INIT_Y1;
      X_Tank2  <= INIT_X2;
      Y_Tank2  <= INIT_Y2;
      face1    <= DIR_UP;
      face2    <= DIR_UP;
      busy     <= 1'b0;
      done     <= 1'b0;
      blocked1 <= 1'b0;
      blocked2 <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            dir1_q   <= sanitize(dir_req1);
            dir2_q   <= sanitize(dir_req2);
            blocked1 <= 1'b0;
            blocked2 <= 1'b0;
            cnt      <= STEPS_L;
            busy     <= 1'b1;
            state    <= PH_A;
          end
        end
        PH_A, PH_B: begin
          if (step_ok) begin
            cnt <= cnt - 4'd1;
            if (served2) begin
              X_Tank2 <= nxt_x;
              Y_Tank2 <= nxt_y;
            end else begin
              X_Tank1 <= nxt_x;
              Y_Tank1 <= nxt_y;
            end
          end
          // Facing follows the request even when the step is refused.
          if (cur_dir != 3'd0) begin
            if (served2) face2 <= cur_dir;
            else         face1 <= cur_dir;
            if (!step_ok) begin
              if (served2) blocked2 <= 1'b1;
              else         blocked1 <= 1'b1;
            end
          end
          if (phase_end) begin
            cnt <= STEPS_L;
            if (state == PH_A) begin
              state <= PH_B;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          first <= ~first;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tank_move_sched.sv
// Bench for tank_move_sched: per-frame behavioural model expanded into expected per-cycle snapshots, plus literal spot checks.
module tb_tank_move_sched;

  localparam int STEPS = 2;
  localparam int XMAX  = 608;
  localparam int YMAX  = 448;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [2:0] dir_req1 = 3'd0;
  logic [2:0] dir_req2 = 3'd0;
  logic [9:0] chk_x, chk_y;
  logic [2:0] chk_dir;
  logic       chk_ok;
  logic [9:0] X_Tank1, Y_Tank1, X_Tank2, Y_Tank2;
  logic [2:0] face1, face2;
  logic       busy, done, blocked1, blocked2;

  int wall_mode = 0;
  int checks = 0;
  int errors = 0;

  tank_move_sched dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
    .dir_req1(dir_req1), .dir_req2(dir_req2),
    .chk_x(chk_x), .chk_y(chk_y), .chk_dir(chk_dir), .chk_ok(chk_ok),
    .X_Tank1(X_Tank1), .Y_Tank1(Y_Tank1), .X_Tank2(X_Tank2), .Y_Tank2(Y_Tank2),
    .face1(face1), .face2(face2), .busy(busy), .done(done),
    .blocked1(blocked1), .blocked2(blocked2)
  );

  always #5 Clk = ~Clk;

  // Wall scenery: 0 open field, 1 walls everywhere, 2 wall to the right, 3 floor at y=65.
  function automatic logic wall_ok(input int mode, input logic [9:0] x, input logic [9:0] y, input logic [2:0] d);
    case (mode)
      1:       return 1'b0;
      2:       return d != 3'd2;
      3:       return !(d == 3'd4 && y == 10'd65 && x <= 10'd639);
      default: return 1'b1;
    endcase
  endfunction

  assign chk_ok = wall_ok(wall_mode, chk_x, chk_y, chk_dir);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int x1, y1, x2, y2, f1, f2, b1, b2;
    int busy, done, phase, cx, cy, cd;
  } rec_t;

  rec_t q[$];
  int mx[2], my[2], mf[2], mb[2];
  int mfirst;
  int m_busy;

  task automatic model_reset();
    q.delete();
    mx[0] = 64;  my[0] = 64;
    mx[1] = 544; my[1] = 384;
    mf[0] = 1;   mf[1] = 1;
    mb[0] = 0;   mb[1] = 0;
    mfirst = 0;
    m_busy = 0;
  endtask

  function automatic rec_t snap(input int phase, input int t, input int d);
    rec_t r;
    r.x1 = mx[0]; r.y1 = my[0]; r.x2 = mx[1]; r.y2 = my[1];
    r.f1 = mf[0]; r.f2 = mf[1]; r.b1 = mb[0]; r.b2 = mb[1];
    r.busy = phase; r.done = 0; r.phase = phase;
    r.cx = mx[t]; r.cy = my[t]; r.cd = d;
    return r;
  endfunction

  function automatic int legal(input int x, input int y, input int d);
    if (!wall_ok(wall_mode, 10'(x), 10'(y), 3'(d))) return 0;
    case (d)
      1:       return (y - 1 >= 0) ? 1 : 0;
      2:       return (x + 1 <= XMAX) ? 1 : 0;
      3:       return (x - 1 >= 0) ? 1 : 0;
      4:       return (y + 1 <= YMAX) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Expand one accepted frame into the outputs expected on each following cycle.
  task automatic build_frame(input int r1, input int r2);
    int d[2];
    rec_t r;
    d[0] = (r1 >= 1 && r1 <= 4) ? r1 : 0;
    d[1] = (r2 >= 1 && r2 <= 4) ? r2 : 0;
    mb[0] = 0; mb[1] = 0;
    for (int p = 0; p < 2; p++) begin
      int t;
      int moved;
      t = (p == 0) ? mfirst : 1 - mfirst;
      moved = 0;
      for (int s = 0; s < 16; s++) begin
        q.push_back(snap(1, t, d[t]));
        if (d[t] == 0) break;
        mf[t] = d[t];
        if (legal(mx[t], my[t], d[t]) != 0) begin
          if (d[t] == 1) my[t]--;
          if (d[t] == 2) mx[t]++;
          if (d[t] == 3) mx[t]--;
          if (d[t] == 4) my[t]++;
          moved++;
          if (moved == STEPS) break;
        end else begin
          mb[t] = 1;
          break;
        end
      end
    end
    r = snap(0, 0, 0);
    r.busy = 1;
    r.done = 1;
    q.push_back(r);
    mfirst = 1 - mfirst;
  endtask

  always @(posedge Clk) begin
    if (Reset_n && frame_tick && q.size() == 0 && m_busy == 0)
      build_frame(int'(dir_req1), int'(dir_req2));
  end

  always @(negedge Clk) begin
    rec_t e;
    if (q.size() > 0) e = q.pop_front();
    else              e = snap(0, 0, 0);
    m_busy = e.busy;
    chk("x1", int'(X_Tank1), e.x1);
    chk("y1", int'(Y_Tank1), e.y1);
    chk("x2", int'(X_Tank2), e.x2);
    chk("y2", int'(Y_Tank2), e.y2);
    chk("face1", int'(face1), e.f1);
    chk("face2", int'(face2), e.f2);
    chk("blocked1", int'(blocked1), e.b1);
    chk("blocked2", int'(blocked2), e.b2);
    chk("busy", int'(busy), e.busy);
    chk("done", int'(done), e.done);
    chk("chk_dir", int'(chk_dir), e.cd);
    if (e.phase != 0) begin
      chk("chk_x", int'(chk_x), e.cx);
      chk("chk_y", int'(chk_y), e.cy);
    end
  end

  task automatic do_reset();
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_x1", int'(X_Tank1), 64);
    chk("rst_y2", int'(Y_Tank2), 384);
    chk("rst_x2", int'(X_Tank2), 544);
    chk("rst_face1", int'(face1), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_blocked1", int'(blocked1), 0);
    @(negedge Clk);
    @(negedge Clk);
    #2 Reset_n = 1'b1;
  endtask

  // Issue a tick held for `hold` clock edges; report the cycle of done and how many dones were seen.
  task automatic run_frame(input int d1, input int d2, input int hold, input int tail,
                           output int done_at, output int n_done, output int first_cx);
    done_at = -1;
    n_done = 0;
    first_cx = -1;
    @(negedge Clk);
    dir_req1 = 3'(d1);
    dir_req2 = 3'(d2);
    frame_tick = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (c == 1) first_cx = int'(chk_x);
      if (c >= hold) frame_tick = 1'b0;
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
      if (done_at > 0 && c >= done_at + tail) break;
    end
    frame_tick = 1'b0;
    if (done_at < 0) chk("frame_timeout", 0, 1);
  endtask

  int da, nd, fc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // Tank 1 right, tank 2 idle.
    run_frame(2, 0, 1, 1, da, nd, fc);
    chk("s1_done_cycle", da, 4);
    chk("s1_x1", int'(X_Tank1), 66);
    chk("s1_face1", int'(face1), 2);

    // Wall to the right of tank 1.
    do_reset();
    wall_mode = 2;
    run_frame(2, 0, 1, 1, da, nd, fc);
    chk("s2_done_cycle", da, 3);
    chk("s2_x1", int'(X_Tank1), 64);
    chk("s2_blocked1", int'(blocked1), 1);
    chk("s2_face1", int'(face1), 2);
    wall_mode = 0;

    // Order alternates across frames.
    do_reset();
    run_frame(4, 4, 1, 1, da, nd, fc);
    chk("s4_first_cx_f1", fc, 64);
    run_frame(4, 4, 1, 1, da, nd, fc);
    chk("s4_first_cx_f2", fc, 544);
    chk("s4_y1", int'(Y_Tank1), 68);
    chk("s4_y2", int'(Y_Tank2), 388);

    // Tick held high while busy.
    run_frame(4, 4, 4, 8, da, nd, fc);
    chk("s5_done_count", nd, 1);
    chk("s5_y1", int'(Y_Tank1), 70);
    chk("s5_y2", int'(Y_Tank2), 390);

    // Invalid codes act as no request.
    run_frame(7, 5, 1, 1, da, nd, fc);
    chk("inv_done_cycle", da, 3);
    chk("inv_face1", int'(face1), 4);

    // Reset during the second phase.
    @(negedge Clk);
    dir_req1 = 3'd2;
    dir_req2 = 3'd4;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    @(negedge Clk);
    do_reset();
    run_frame(2, 0, 1, 1, da, nd, fc);
    chk("s6_done_cycle", da, 4);
    chk("s6_x1", int'(X_Tank1), 66);

    // Screen edges: tank 1 to X=0, tank 2 to X=X_MAX.
    for (int i = 0; i < 34; i++) run_frame(3, 2, 1, 1, da, nd, fc);
    chk("s3_x1_edge", int'(X_Tank1), 0);
    chk("s3_blocked1_left", int'(blocked1), 1);
    chk("s3_x2_edge", int'(X_Tank2), 608);
    chk("s3_blocked2_right", int'(blocked2), 1);
    wall_mode = 3;
    run_frame(4, 0, 1, 1, da, nd, fc);
    chk("s3_y1_floor", int'(Y_Tank1), 65);
    chk("s3_blocked1_floor", int'(blocked1), 1);
    wall_mode = 0;
    for (int i = 0; i < 191; i++) run_frame(4, 1, 1, 1, da, nd, fc);
    chk("s3_y1_447", int'(Y_Tank1), 447);
    run_frame(4, 1, 1, 1, da, nd, fc);
    chk("s3_y1_bottom", int'(Y_Tank1), 448);
    chk("s3_blocked1_bottom", int'(blocked1), 1);
    chk("s3_y2_top", int'(Y_Tank2), 0);
    chk("s3_blocked2_free", int'(blocked2), 0);
    run_frame(0, 1, 1, 1, da, nd, fc);
    chk("s3_y2_stays", int'(Y_Tank2), 0);
    chk("s3_blocked2_top", int'(blocked2), 1);
    chk("s3_blocked1_idle", int'(blocked1), 0);

    @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
